// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: control inputs from the decoder and PC/status outputs of the fetch stage.
interface pc_fetch_ctrl_if #(parameter int CNT_W = 16);
  logic             run_en;
  logic             branch_taken;
  logic [31:0]      branch_off;
  logic             jump;
  logic [25:0]      jump_idx;
  logic             halt_req;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             fetch_valid;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;
  modport master (
    output run_en, branch_taken, branch_off, jump, jump_idx, halt_req,
    input  pc, pc_plus4, fetch_valid, halted, fault, retired
  );
  modport slave (
    input  run_en, branch_taken, branch_off, jump, jump_idx, halt_req,
    output pc, pc_plus4, fetch_valid, halted, fault, retired
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, next-PC select and run/stall/halt control ahead of instruction memory.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          CNT_W      = 16
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_ctrl_if.slave bus
);
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t           state, state_nxt;
  logic [31:0]      pc_q, pc_nxt, pc_plus4, next_pc;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             fault_q, fault_nxt, adv, oor;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      cnt_q   <= cnt_nxt;
      fault_q <= fault_nxt;
    end
  // An out-of-range target halts without retiring, and outranks halt_req.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    next_pc   = bus.jump ? {pc_plus4[31:28], bus.jump_idx, 2'b00}
              : bus.branch_taken ? pc_plus4 + (bus.branch_off << 2) : pc_plus4;
    oor       = next_pc >= LIMIT;
    adv       = state == RUN && bus.run_en;
    state_nxt = state == IDLE ? (bus.run_en ? RUN : IDLE)
              : state == RUN ? (adv && (oor || bus.halt_req) ? HALT : RUN) : HALT;
    pc_nxt    = adv && !oor ? next_pc : pc_q;
    cnt_nxt   = adv && !oor ? cnt_q + CNT_W'(1) : cnt_q;
    fault_nxt = fault_q | (adv & oor);
  end
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = state == RUN;
  assign bus.halted      = state == HALT;
  assign bus.fault       = fault_q;
  assign bus.retired     = cnt_q;
endmodule
